// File: rtl/mblock_stage_sequencer_if.sv
// Memory-block access bus between the stage sequencer and the address mux / RAM / BROM side.
interface mblock_stage_sequencer_if;
    logic       mem_req;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [3:0] is_stage;
    logic [1:0] mblock_selector;
    logic [3:0] is_write;

    modport master (
        output mem_req, is_stage, mblock_selector, is_write,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, is_stage, mblock_selector, is_write,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mblock_stage_sequencer.sv
// Steps one instruction through fetch, two operand reads and a result access,
// handshaking each access with the memory side and faulting on ack timeout.
module mblock_stage_sequencer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            run,
    input  logic                            execute_from_brom,
    mblock_stage_sequencer_if.master        mem,
    output logic [7:0]                      instr_op,
    output logic                            pc_advance,
    output logic                            fault
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned OP_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC0  = 3'd1,
        S_ACC1  = 3'd2,
        S_ACC2  = 3'd3,
        S_ACC3  = 3'd4,
        S_FAULT = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              brom_q, brom_d;
    logic              pc_adv_q, pc_adv_d;
    logic              in_access;

    assign in_access = (state_q == S_ACC0) || (state_q == S_ACC1) ||
                       (state_q == S_ACC2) || (state_q == S_ACC3);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wait_q   <= '0;
            op_q     <= '0;
            brom_q   <= 1'b0;
            pc_adv_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            op_q     <= op_d;
            brom_q   <= brom_d;
            pc_adv_q <= pc_adv_d;
        end
    end

    // Next state: advance on ack, fault when the wait budget runs out
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        op_d     = op_q;
        brom_d   = brom_q;
        pc_adv_d = 1'b0;

        if (state_q == S_IDLE) begin
            wait_d = '0;
            if (run) begin
                state_d = S_ACC0;
                brom_d  = execute_from_brom;
            end
        end else if (in_access) begin
            if (mem.mem_ack) begin
                wait_d = '0;
                unique case (state_q)
                    S_ACC0: begin
                        op_d    = mem.mem_rdata;
                        state_d = S_ACC1;
                    end
                    S_ACC1:  state_d = op_q[7] ? S_ACC3 : S_ACC2;
                    S_ACC2:  state_d = S_ACC3;
                    default: begin
                        pc_adv_d = 1'b1;
                        if (run) begin
                            state_d = S_ACC0;
                            brom_d  = execute_from_brom;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                endcase
            end else if (wait_q == CNT_W'(WAIT_MAX)) begin
                state_d = S_FAULT;
            end else begin
                wait_d = wait_q + CNT_W'(1);
            end
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        mem.mem_req         = 1'b0;
        mem.is_stage        = 4'b0000;
        mem.mblock_selector = 2'b00;
        mem.is_write        = 4'b0000;
        fault               = 1'b0;
        unique case (state_q)
            S_ACC0: begin
                mem.mem_req         = 1'b1;
                mem.is_stage        = 4'b0001;
                mem.mblock_selector = {1'b0, brom_q};
            end
            S_ACC1: begin
                mem.mem_req         = 1'b1;
                mem.is_stage        = 4'b0010;
                mem.mblock_selector = op_q[1:0];
            end
            S_ACC2: begin
                mem.mem_req         = 1'b1;
                mem.is_stage        = 4'b0100;
                mem.mblock_selector = op_q[3:2];
            end
            S_ACC3: begin
                mem.mem_req         = 1'b1;
                mem.is_stage        = 4'b1000;
                mem.mblock_selector = op_q[5:4];
                mem.is_write        = {op_q[6], 3'b000};
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

    assign instr_op   = op_q;
    assign pc_advance = pc_adv_q;

endmodule

// File: tb/tb_mblock_stage_sequencer.sv
// Directed and random stimulus against an integer-stage reference model of the sequencer.
module tb_mblock_stage_sequencer;

    localparam int unsigned WAIT_MAX = 4;
    localparam int          ST_IDLE  = -1;
    localparam int          ST_FAULT = 4;

    logic       clk;
    logic       reset;
    logic       run;
    logic       execute_from_brom;
    logic [7:0] instr_op;
    logic       pc_advance;
    logic       fault;

    mblock_stage_sequencer_if mif ();

    mblock_stage_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk               (clk),
        .reset             (reset),
        .run               (run),
        .execute_from_brom (execute_from_brom),
        .mem               (mif),
        .instr_op          (instr_op),
        .pc_advance        (pc_advance),
        .fault             (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stage as an integer, outputs derived arithmetically
    int         m_stage = ST_IDLE;
    int         m_wait  = 0;
    logic [7:0] m_op    = 8'h00;
    logic       m_brom  = 1'b0;
    logic       m_pcadv = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic rn, input logic br,
                              input logic ack, input logic [7:0] rd);
        if (r) begin
            m_stage = ST_IDLE; m_wait = 0; m_op = 8'h00; m_brom = 1'b0; m_pcadv = 1'b0;
            return;
        end
        m_pcadv = 1'b0;
        if (m_stage == ST_IDLE) begin
            if (rn) begin m_stage = 0; m_brom = br; m_wait = 0; end
        end else if (m_stage == ST_FAULT) begin
            m_stage = ST_FAULT;
        end else if (ack) begin
            m_wait = 0;
            if (m_stage == 0) begin
                m_op = rd; m_stage = 1;
            end else if (m_stage == 1) begin
                m_stage = m_op[7] ? 3 : 2;
            end else if (m_stage == 2) begin
                m_stage = 3;
            end else begin
                m_pcadv = 1'b1;
                if (rn) begin m_stage = 0; m_brom = br; end
                else m_stage = ST_IDLE;
            end
        end else if (m_wait == int'(WAIT_MAX)) begin
            m_stage = ST_FAULT;
        end else begin
            m_wait++;
        end
    endtask

    task automatic compare_all();
        logic        active;
        logic [31:0] exp_stage, exp_sel, exp_wr;
        active    = (m_stage >= 0) && (m_stage <= 3);
        exp_stage = active ? (32'd1 << m_stage) : 32'd0;
        if (!active)          exp_sel = 32'd0;
        else if (m_stage == 0) exp_sel = {31'd0, m_brom};
        else                  exp_sel = (32'(m_op) >> (2 * (m_stage - 1))) & 32'd3;
        exp_wr = (m_stage == 3 && m_op[6]) ? 32'd8 : 32'd0;
        check_eq("is_stage",   32'(mif.is_stage),        exp_stage);
        check_eq("selector",   32'(mif.mblock_selector), exp_sel);
        check_eq("is_write",   32'(mif.is_write),        exp_wr);
        check_eq("mem_req",    32'(mif.mem_req),         32'(active));
        check_eq("instr_op",   32'(instr_op),            32'(m_op));
        check_eq("pc_advance", 32'(pc_advance),          32'(m_pcadv));
        check_eq("fault",      32'(fault),               32'(m_stage == ST_FAULT));
    endtask

    task automatic step(input logic r, input logic rn, input logic br,
                        input logic ack, input logic [7:0] rd);
        reset             = r;
        run               = rn;
        execute_from_brom = br;
        mif.mem_ack       = ack;
        mif.mem_rdata     = rd;
        @(posedge clk);
        model_step(r, rn, br, ack, rd);
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; execute_from_brom = 1'b0;
        mif.mem_ack = 1'b0; mif.mem_rdata = 8'h00;

        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF);

        // Full instruction with all four stages and a stage-3 write
        repeat (9) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h4E);
        // Stage-2 skip
        repeat (7) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h80);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Delayed stage-1 ack, then run dropped mid-instruction
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h35);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
        repeat (6) step(1'b0, 1'b0, 1'b1, 1'b1, 8'hAA);

        // execute_from_brom toggled during stage 2
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h1B);
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);

        // Timeout in stage 0, sticky fault, then reset mid-stage-2
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (9) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 8'h7F);
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'h7F);

        // Random traffic with varying ack density and occasional resets
        for (int i = 0; i < 4000; i++) begin
            int unsigned ack_pct;
            ack_pct = (i < 2000) ? 75 : 90;
            step(($urandom_range(199) == 0),
                 ($urandom_range(99) < 80),
                 1'($urandom),
                 ($urandom_range(99) < ack_pct),
                 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mblock_stage_sequencer.md
# mblock_stage_sequencer

Sequences the four memory-block stages of one instruction: fetch (stage 0), operand reads (stages 1–2) and result access (stage 3). It drives the stage one-hot, the 2-bit memory-block selector and the per-stage write strobes consumed by the memory-block address mux. It handshakes every access with the memory side and latches the instruction op byte fetched in stage 0. It sits between the CPU top-level control and the memory-block mux/RAM/BROM.

## Interface
Parameters:
- WAIT_MAX, 15: max cycles `mem_req` may wait for `mem_ack` before a fault (1..255).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- run  in  1  start/continue executing instructions
- execute_from_brom  in  1  fetch source: 1 = BROM, 0 = RAM
- mem_ack  in  1  memory side completes current access this cycle
- mem_rdata  in  8  read data; valid when mem_req & mem_ack
- is_stage  out  4  one-hot active stage, bit s = stage s; 0000 when idle
- mblock_selector  out  2  address-source select for the mux
- is_write  out  4  one-hot write strobe; only bit 3 can be set
- mem_req  out  1  access request, held until acknowledged
- instr_op  out  8  op byte latched at stage-0 completion
- pc_advance  out  1  one-cycle pulse after stage 3 completes
- fault  out  1  sticky ack-timeout flag, cleared only by reset

## Operation
- States: IDLE, ACCESS(s) for s = 0..3, FAULT.
- Reset (any state, including mid-access) -> IDLE. Outputs after reset: is_stage=0000, mblock_selector=00, is_write=0000, mem_req=0, instr_op=00, pc_advance=0, fault=0.
- IDLE: when run=1, go to ACCESS(0) next cycle and latch execute_from_brom into brom_q.
- ACCESS(0): mblock_selector={1'b0, brom_q}. On mem_req&mem_ack, instr_op <= mem_rdata, then go to ACCESS(1).
- ACCESS(1): mblock_selector=instr_op[1:0].
- ACCESS(2): mblock_selector=instr_op[3:2]. It is skipped when instr_op[7]=1 (ACCESS(1) -> ACCESS(3)).
- ACCESS(3): mblock_selector=instr_op[5:4] and is_write=instr_op[6]<<3. On completion, pulse pc_advance. Next state is ACCESS(0) if run=1, else IDLE. For the ACCESS(0) case, re-latch brom_q.
- In every ACCESS state: mem_req=1 and is_stage=1<<s. is_write is 0000 except in ACCESS(3).
- run is sampled only at instruction boundaries (IDLE, or stage-3 completion). Deasserting run mid-instruction does not abort the instruction.
- execute_from_brom changes mid-instruction are ignored until the next fetch.
- Timeout: a wait counter (8 bit) clears on entry to each ACCESS state and increments each cycle that mem_req=1 and mem_ack=0. When it reaches WAIT_MAX with ack still low, go to FAULT.
- FAULT: fault=1, mem_req=0, is_stage=0000, is_write=0000. Held until reset; run is ignored.
- mem_ack is ignored while mem_req=0.

## Timing
- All outputs are registered, or decoded from registered state only. There is no combinational path from inputs to outputs.
- An access completes in the cycle where mem_req=1 and mem_ack=1. The next stage's mem_req is asserted in the following cycle, so back-to-back accesses are allowed.
- Minimum instruction: 4 cycles (3 with the stage-2 skip).
- pc_advance is high in the cycle after stage-3 completion, coincident with ACCESS(0) of the next instruction or with IDLE.
- IDLE with run=1 -> is_stage=0001 one cycle later.
- Timeout: with no ack, fault rises WAIT_MAX+1 cycles after entering the ACCESS state.
- instr_op updates in the cycle after stage-0 completion and is stable through stage 3.

## Test plan
- Reset then run=1, execute_from_brom=1, mem_ack=1 constant, mem_rdata=8'h4E -> is_stage 0001,0010,0100,1000 on consecutive cycles. mblock_selector 01,10,11,00. is_write=1000 in stage 3. pc_advance one cycle later.
- mem_rdata=8'h80 at fetch, ack constant -> is_stage 0001,0010,1000. Stage 2 is never active. is_write stays 0000.
- Ack delayed 3 cycles on stage 1 -> mem_req and is_stage=0010 held 4 cycles. instr_op is unchanged. Stage 2 begins the cycle after ack.
- run dropped during stage 1 -> stages 2 and 3 still complete, pc_advance pulses, then IDLE with all outputs 0.
- WAIT_MAX=4, no ack in stage 0 -> fault=1 after 5 cycles and stays set until reset. Asserting reset mid-stage-2 -> all outputs at reset values next cycle.
- execute_from_brom toggled 1->0 during stage 2 -> the next stage-0 mblock_selector is 00 and the current instruction is unaffected.
